// File: rtl/store_align_unit_if.sv
// Store request / memory write-beat bundle for store_align_unit.
// slave = aligner view, master = requester-and-memory view.
interface store_align_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [2:0]              req_funct3;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic                    done;
  logic                    store_err;

  modport slave (
    input  req_valid, req_addr, req_funct3,
    input  req_wdata, mem_ready,
    output req_ready, mem_valid, mem_addr,
    output mem_wdata, mem_be, done, store_err
  );

  modport master (
    output req_valid, req_addr, req_funct3,
    output req_wdata, mem_ready,
    input  req_ready, mem_valid, mem_addr,
    input  mem_wdata, mem_be, done, store_err
  );
endinterface

// File: rtl/store_align_unit.sv
// Store aligner: lane-shifts sb/sh/sw/sd data onto the memory bus,
// splitting word-crossing stores into two beats or rejecting them.
module store_align_unit #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  store_align_unit_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE,
    BEAT1,
    BEAT2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              sz_q;
  logic [LW-1:0]           off_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    cross_q;
  logic                    err_q;

  logic                    accept;
  logic                    legal;
  logic                    cross_in;
  logic                    reject;
  logic [LW-1:0]           off_in;

  assign off_in   = bus.req_addr[LW-1:0];
  assign accept   = bus.req_valid && (state == IDLE);
  assign legal    = !bus.req_funct3[2] &&
                    ((bus.req_funct3[1:0] != 2'b11) ||
                     (DATA_WIDTH == 64));
  assign cross_in = (int'(off_in) +
                     (1 << int'(bus.req_funct3[1:0]))) > NB;
  assign reject   = !legal ||
                    ((ALLOW_MISALIGNED == 0) && cross_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      sz_q    <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && reject;
      case (state)
        IDLE: begin
          if (accept && !reject) begin
            addr_q  <= {bus.req_addr[ADDR_WIDTH-1:LW],
                        {LW{1'b0}}};
            sz_q    <= bus.req_funct3[1:0];
            off_q   <= off_in;
            wdata_q <= bus.req_wdata;
            cross_q <= cross_in;
            state   <= BEAT1;
          end
        end
        BEAT1: begin
          if (bus.mem_ready)
            state <= cross_q ? BEAT2 : IDLE;
        end
        BEAT2: begin
          if (bus.mem_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift into a double-width window; low half is beat 1, high half beat 2.
  logic [NB-1:0]           mask;
  logic [2*NB-1:0]         wide_be;
  logic [2*DATA_WIDTH-1:0] wide_d;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++)
      mask[i] = (i < (1 << sz_q));
  end

  assign wide_be = {{NB{1'b0}}, mask} << off_q;
  assign wide_d  = {{DATA_WIDTH{1'b0}}, wdata_q}
                   << (8 * int'(off_q));

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      (state == BEAT1): begin
        bus.mem_addr  = addr_q;
        bus.mem_be    = wide_be[NB-1:0];
        bus.mem_wdata = wide_d[DATA_WIDTH-1:0];
      end
      (state == BEAT2): begin
        bus.mem_addr  = addr_q + ADDR_WIDTH'(NB);
        bus.mem_be    = wide_be[2*NB-1:NB];
        bus.mem_wdata = wide_d[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.mem_valid = (state != IDLE);
  assign bus.store_err = err_q;
  assign bus.done      = bus.mem_valid && bus.mem_ready &&
                         ((state == BEAT2) ||
                          ((state == BEAT1) && !cross_q));
endmodule
